// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Assembles the serial byte stream from the UART receiver into instruction
//   words and writes them to consecutive instruction-memory addresses.
//   A load ends on the halt word, at capacity, or on an inter-byte timeout.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous reset, active-low
//   i_start           start / restart a load (level, sampled every cycle)
//   i_rx_done         one-cycle strobe: i_rx_data holds a received byte
//   i_rx_data         received byte
//   o_write_inst_mem  instruction-memory write strobe (one cycle per word)
//   o_inst_mem_addr   write address
//   o_inst_mem_data   write data (assembled word)
//   o_busy            high while receiving or writing
//   o_done            load completed (sticky until the next start)
//   o_error           inter-byte timeout abort (sticky until the next start)
//   o_word_count      words written in the current / last load
//
// Handshake: there is no back-pressure. A byte is taken on every cycle where
// i_rx_done is high while a load is active (RECV or WRITE) and i_start is low;
// o_write_inst_mem is a single-cycle strobe with address and data valid in
// that same cycle.
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int                      WORD_BYTES     = 4,
    parameter int                      ADDR_BITS      = 11,
    parameter int                      MAX_WORDS      = 2048,
    parameter bit                      BIG_ENDIAN     = 1'b1,
    parameter logic [8*WORD_BYTES-1:0] HALT_WORD      = '1,
    parameter int                      TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_rx_done,
    input  logic [7:0]                i_rx_data,
    output logic                      o_write_inst_mem,
    output logic [ADDR_BITS-1:0]      o_inst_mem_addr,
    output logic [8*WORD_BYTES-1:0]   o_inst_mem_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [ADDR_BITS:0]        o_word_count
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int KW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [KW-1:0]      LAST_SLOT = KW'(WORD_BYTES - 1);
    localparam logic [TW-1:0]      TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_BITS:0] MAX_CNT   = (ADDR_BITS + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state, state_next;
    logic [KW-1:0]        byte_idx, byte_idx_next;
    logic [W-1:0]         asm_word, asm_word_next;
    logic [TW-1:0]        timer, timer_next;
    logic [ADDR_BITS-1:0] addr_next;
    logic [ADDR_BITS:0]   count_next, count_inc;
    logic [W-1:0]         data_next;
    logic                 capture, last_slot;

    // Bytes are accepted in RECV and also in the WRITE cycle, so a byte that
    // arrives right behind a completed word becomes slot 0 of the next word.
    // A simultaneous start wins and drops the byte.
    assign capture   = i_rx_done && !i_start && (state == S_RECV || state == S_WRITE);
    assign last_slot = (byte_idx == LAST_SLOT);

    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        asm_word_next = asm_word;
        timer_next    = timer;
        addr_next     = o_inst_mem_addr;
        count_next    = o_word_count;
        data_next     = o_inst_mem_data;
        count_inc     = o_word_count + (ADDR_BITS + 1)'(1);

        if (capture) begin
            // Slot k lands in lane WORD_BYTES-1-k (big-endian) or lane k.
            for (int i = 0; i < WORD_BYTES; i++) begin
                if ((BIG_ENDIAN ? (WORD_BYTES - 1 - i) : i) == int'(byte_idx)) begin
                    asm_word_next[i*8 +: 8] = i_rx_data;
                end
            end
            byte_idx_next = last_slot ? '0 : byte_idx + KW'(1);
            timer_next    = '0;
            if (last_slot) begin
                data_next = asm_word_next;
            end
        end

        if (i_start) begin
            // Start and restart are the same from every state; a write
            // already on the port this cycle still completes.
            state_next    = S_RECV;
            addr_next     = '0;
            count_next    = '0;
            byte_idx_next = '0;
            timer_next    = '0;
        end else begin
            case (state)
                S_RECV: begin
                    if (capture) begin
                        if (last_slot) begin
                            state_next = S_WRITE;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && byte_idx != '0) begin
                        // Only a partially received word can time out.
                        if (timer == TMO_LAST) begin
                            state_next    = S_ERROR;
                            byte_idx_next = '0;
                        end else begin
                            timer_next = timer + TW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    count_next = count_inc;
                    // Hold the address at capacity so it never wraps.
                    if (count_inc != MAX_CNT) begin
                        addr_next = o_inst_mem_addr + ADDR_BITS'(1);
                    end
                    if (o_inst_mem_data == HALT_WORD || count_inc == MAX_CNT) begin
                        state_next = S_DONE;
                    end else if (capture && last_slot) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_RECV;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            byte_idx         <= '0;
            asm_word         <= '0;
            timer            <= '0;
            o_write_inst_mem <= 1'b0;
            o_inst_mem_addr  <= '0;
            o_inst_mem_data  <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
            o_word_count     <= '0;
        end else begin
            state            <= state_next;
            byte_idx         <= byte_idx_next;
            asm_word         <= asm_word_next;
            timer            <= timer_next;
            o_inst_mem_addr  <= addr_next;
            o_inst_mem_data  <= data_next;
            o_word_count     <= count_next;
            // Status flags are registered copies of the state being entered.
            o_write_inst_mem <= (state_next == S_WRITE);
            o_busy           <= (state_next == S_RECV) || (state_next == S_WRITE);
            o_done           <= (state_next == S_DONE);
            o_error          <= (state_next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  // dut_a: 4-byte big-endian words, capacity 4, timeout 50
  logic        a_wr, a_busy, a_done, a_err;
  logic [10:0] a_addr;
  logic [31:0] a_data;
  logic [11:0] a_cnt;

  // dut_b: 2-byte little-endian words, capacity 8 (full 3-bit space), no timeout
  logic        b_wr, b_busy, b_done, b_err;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  logic [3:0]  b_cnt;

  inst_loader #(
    .WORD_BYTES(4), .ADDR_BITS(11), .MAX_WORDS(4), .BIG_ENDIAN(1'b1),
    .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(50)
  ) dut_a (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_write_inst_mem(a_wr), .o_inst_mem_addr(a_addr), .o_inst_mem_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_err), .o_word_count(a_cnt)
  );

  inst_loader #(
    .WORD_BYTES(2), .ADDR_BITS(3), .MAX_WORDS(8), .BIG_ENDIAN(1'b0),
    .HALT_WORD(16'hFFFF), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_write_inst_mem(b_wr), .o_inst_mem_addr(b_addr), .o_inst_mem_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_err), .o_word_count(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  localparam int M_IDLE = 0, M_RECV = 1, M_WR = 2, M_DONE = 3, M_ERR = 4;

  function automatic int nb(input int d);   return (d == 0) ? 4 : 2; endfunction
  function automatic int maxw(input int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int tmo(input int d);  return (d == 0) ? 50 : 0; endfunction
  function automatic logic [31:0] halt(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  int          m_mode[2];
  int          m_addr[2];
  int          m_cnt[2];
  int          m_idle[2];
  int          m_pn[2];
  logic [7:0]  m_pend[2][4];
  logic [31:0] m_word[2];
  logic [43:0] exp_q_a[$];
  logic [43:0] exp_q_b[$];

  task automatic model_restart(input int d);
    m_mode[d] = M_RECV; m_addr[d] = 0; m_cnt[d] = 0; m_idle[d] = 0; m_pn[d] = 0;
  endtask

  task automatic model_take(input int d);
    logic [31:0] w;
    m_pend[d][m_pn[d]] = rx_data;
    m_pn[d]++;
    m_idle[d] = 0;
    if (m_pn[d] == nb(d)) begin
      w = 32'h0;
      for (int i = 0; i < nb(d); i++) begin
        if (d == 0) w = w * 256 + 32'(m_pend[d][i]);
        else        w = w + (32'(m_pend[d][i]) << (8 * i));
      end
      m_word[d] = w;
      m_pn[d] = 0;
      m_mode[d] = M_WR;
      if (d == 0) exp_q_a.push_back({12'(m_addr[d]), w});
      else        exp_q_b.push_back({12'(m_addr[d]), w});
    end
  endtask

  task automatic model_step(input int d);
    if (!rst) begin
      m_mode[d] = M_IDLE; m_addr[d] = 0; m_cnt[d] = 0; m_idle[d] = 0; m_pn[d] = 0;
    end else if (start) begin
      model_restart(d);
    end else begin
      case (m_mode[d])
        M_RECV: begin
          if (rx_done) model_take(d);
          else if (m_pn[d] > 0 && tmo(d) != 0) begin
            m_idle[d]++;
            if (m_idle[d] >= tmo(d)) begin m_mode[d] = M_ERR; m_pn[d] = 0; end
          end
        end
        M_WR: begin
          m_addr[d]++;
          m_cnt[d]++;
          if (m_word[d] == halt(d) || m_cnt[d] == maxw(d)) begin
            m_mode[d] = M_DONE; m_pn[d] = 0;
          end else begin
            m_mode[d] = M_RECV;
            if (rx_done) model_take(d);
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_dut(input int d, input logic wr, input logic [11:0] addr,
                         input logic [31:0] data, input logic busy, input logic done,
                         input logic err, input logic [11:0] cnt);
    logic [43:0] e;
    string t;
    t = (d == 0) ? "a" : "b";
    chk({t, "_model_wr"},    64'(wr),   64'(m_mode[d] == M_WR));
    chk({t, "_model_busy"},  64'(busy), 64'(m_mode[d] == M_RECV || m_mode[d] == M_WR));
    chk({t, "_model_done"},  64'(done), 64'(m_mode[d] == M_DONE));
    chk({t, "_model_error"}, 64'(err),  64'(m_mode[d] == M_ERR));
    chk({t, "_model_count"}, 64'(cnt),  64'(m_cnt[d]));
    if (m_mode[d] == M_WR) begin
      e = '0;
      if (d == 0) begin if (exp_q_a.size() > 0) e = exp_q_a.pop_front(); end
      else        begin if (exp_q_b.size() > 0) e = exp_q_b.pop_front(); end
      chk({t, "_model_addr"}, 64'(addr), 64'(e[43:32]));
      chk({t, "_model_data"}, 64'(data), 64'(e[31:0]));
    end
  endtask

  // ---------------- driver ----------------
  int a_seen = 0;
  int a_log[16];

  task automatic tick();
    @(negedge clk);
    if (a_wr === 1'b1) begin
      a_log[a_seen % 16] = int'(a_addr);
      a_seen++;
    end
    cmp_dut(0, a_wr, 12'(a_addr), a_data, a_busy, a_done, a_err, a_cnt);
    cmp_dut(1, b_wr, 12'(b_addr), 32'(b_data), b_busy, b_done, b_err, 12'(b_cnt));
  endtask

  task automatic cyc(input logic s, input logic r, input logic [7:0] d);
    start = s; rx_done = r; rx_data = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a_wr"},   64'(a_wr),   64'd0);
    chk({tag, "_a_addr"}, 64'(a_addr), 64'd0);
    chk({tag, "_a_data"}, 64'(a_data), 64'd0);
    chk({tag, "_a_flags"}, 64'({a_busy, a_done, a_err}), 64'd0);
    chk({tag, "_a_cnt"},  64'(a_cnt),  64'd0);
    chk({tag, "_b_wr"},   64'(b_wr),   64'd0);
    chk({tag, "_b_addr"}, 64'(b_addr), 64'd0);
    chk({tag, "_b_data"}, 64'(b_data), 64'd0);
    chk({tag, "_b_flags"}, 64'({b_busy, b_done, b_err}), 64'd0);
    chk({tag, "_b_cnt"},  64'(b_cnt),  64'd0);
  endtask

  // ---------------- directed vector table for dut_a ----------------
  typedef struct packed {
    logic        s;
    logic        r;
    logic [7:0]  d;
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [11:0] cnt;
  } vec_t;

  vec_t tbl[19];

  int  seen0;
  logic s_r, r_r;
  logic [7:0] d_r;
  int gap;

  initial begin
    // two words, halt word, then bytes that must be ignored in DONE
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h20, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h01, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 11'd0, 32'h2001_0005, 1'b1, 1'b0, 12'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h8C, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd1};
    tbl[6]  = '{1'b0, 1'b1, 8'h02, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h04, 1'b1, 11'd1, 32'h8C02_0004, 1'b1, 1'b0, 12'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd2};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd2};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd2};
    tbl[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, 11'd0, 32'h0,         1'b1, 1'b0, 12'd2};
    tbl[13] = '{1'b0, 1'b1, 8'hFF, 1'b1, 11'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 12'd2};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,         1'b0, 1'b1, 12'd3};
    tbl[15] = '{1'b0, 1'b1, 8'h11, 1'b0, 11'd0, 32'h0,         1'b0, 1'b1, 12'd3};
    tbl[16] = '{1'b0, 1'b1, 8'h22, 1'b0, 11'd0, 32'h0,         1'b0, 1'b1, 12'd3};
    tbl[17] = '{1'b0, 1'b1, 8'h33, 1'b0, 11'd0, 32'h0,         1'b0, 1'b1, 12'd3};
    tbl[18] = '{1'b0, 1'b1, 8'h44, 1'b0, 11'd0, 32'h0,         1'b0, 1'b1, 12'd3};

    // reset
    rst = 1'b0;
    idle(2);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle(2);

    // big-endian words, strobe latency, halt termination
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].s, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d_wr", i),   64'(a_wr),   64'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 64'(a_done), 64'(tbl[i].done));
      chk($sformatf("tbl%0d_cnt", i),  64'(a_cnt),  64'(tbl[i].cnt));
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_addr", i), 64'(a_addr), 64'(tbl[i].addr));
        chk($sformatf("tbl%0d_data", i), 64'(a_data), 64'(tbl[i].data));
      end
    end

    // little-endian 2-byte word on dut_b
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h34);
    cyc(1'b0, 1'b1, 8'h12);
    chk("le_wr",   64'(b_wr),   64'd1);
    chk("le_addr", 64'(b_addr), 64'd0);
    chk("le_data", 64'(b_data), 64'h1234);
    idle(1);
    chk("le_wr_off", 64'(b_wr),  64'd0);
    chk("le_cnt",    64'(b_cnt), 64'd1);

    // inter-byte timeout, then recovery
    cyc(1'b1, 1'b0, 8'h00);
    chk("tmo_err_cleared", 64'(a_err), 64'd0);
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b1, 8'h22);
    seen0 = a_seen;
    idle(45);
    chk("tmo_err_early",  64'(a_err),  64'd0);
    chk("tmo_busy_early", 64'(a_busy), 64'd1);
    idle(15);
    chk("tmo_err",      64'(a_err),  64'd1);
    chk("tmo_busy",     64'(a_busy), 64'd0);
    chk("tmo_no_write", 64'(a_seen - seen0), 64'd0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("tmo_err_clear", 64'(a_err), 64'd0);
    cyc(1'b0, 1'b1, 8'hDE);
    cyc(1'b0, 1'b1, 8'hAD);
    cyc(1'b0, 1'b1, 8'hBE);
    cyc(1'b0, 1'b1, 8'hEF);
    chk("tmo_rec_wr",   64'(a_wr),   64'd1);
    chk("tmo_rec_addr", 64'(a_addr), 64'd0);
    chk("tmo_rec_data", 64'(a_data), 64'hDEAD_BEEF);
    idle(1);

    // capacity: dut_a stops after 4 words, dut_b after 8
    a_seen = 0;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i));
    idle(1);
    chk("cap_writes", 64'(a_seen), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("cap_addr%0d", i), 64'(a_log[i]), 64'(i));
    chk("cap_done",   64'(a_done), 64'd1);
    chk("cap_cnt",    64'(a_cnt),  64'd4);
    chk("cap_b_done", 64'(b_done), 64'd1);
    chk("cap_b_cnt",  64'(b_cnt),  64'd8);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i));
    idle(1);
    chk("cap_ignored", 64'(a_seen), 64'd4);

    // restart mid-word; start beats a simultaneous byte
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 8'(8'h01 + i));
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b1, 8'h22);
    cyc(1'b0, 1'b1, 8'h33);
    cyc(1'b0, 1'b1, 8'h44);
    chk("rst_wr",   64'(a_wr),   64'd1);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_data", 64'(a_data), 64'h1122_3344);
    idle(1);
    chk("rst_cnt",  64'(a_cnt),  64'd1);

    // reset mid-word, coinciding with the final byte
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h51);
    cyc(1'b0, 1'b1, 8'h52);
    cyc(1'b0, 1'b1, 8'h53);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h54);
    chk_zero_outputs("midrst");
    rst = 1'b1;
    seen0 = a_seen;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i));
    idle(1);
    chk("idle_ignores_rx", 64'(a_seen - seen0), 64'd0);
    chk("idle_not_busy",   64'(a_busy), 64'd0);

    // randomized traffic against the reference model
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      if (gap > 0) begin
        gap--;
        r_r = 1'b0;
      end else begin
        r_r = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 59) == 0) gap = $urandom_range(30, 70);
      end
      s_r = ($urandom_range(0, 49) == 0);
      d_r = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 599) != 0);
      cyc(s_r, r_r, d_r);
    end
    rst = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
